vibrato_lfo: RTL

Sine low-frequency oscillator feeding the vibrato stage's `sin` modulation input. It runs on the system clock and detects each rising edge of the audio sample clock ADCLRCK. On each such edge it advances a phase accumulator and produces an offset, depth-scaled sine value in the range 0..2*AMP. The vibrato stage maps this value onto delay-line length, where (240*sin)>>9 yields 0..240 samples.

---
 rtl/lfo_pkg.sv | 32 +++
 rtl/sine_quarter_rom.sv | 32 +++
 rtl/vibrato_lfo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lfo_pkg.sv
// Shared types and defaults for the vibrato sine LFO: FSM states, quadrant
// encoding and the quarter-wave table generator.
package lfo_pkg;

    localparam int PHASE_W_DEF = 24;
    localparam int LUT_AW_DEF  = 8;
    localparam int AMP_DEF     = 256;
    localparam int LUT_DW      = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        LOOKUP  = 2'd2,
        OUTPUT  = 2'd3
    } lfo_state_t;

    // Quadrant = top two phase bits. UP/DOWN is the direction of |sin|,
    // so the DOWN quadrants read the table mirrored.
    typedef enum logic [1:0] {
        Q0_POS_UP   = 2'd0,
        Q1_POS_DOWN = 2'd1,
        Q2_NEG_UP   = 2'd2,
        Q3_NEG_DOWN = 2'd3
    } quadrant_t;

    function automatic logic [LUT_DW-1:0] quarter_sine(input int idx, input int aw, input int amp);
        real angle;
        angle = 1.5707963267948966 * real'(idx) / real'(2 ** aw);
        return LUT_DW'($rtoi(real'(amp) * $sin(angle) + 0.5));
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with a registered read port (1-cycle latency).
// Contents are computed at elaboration from lfo_pkg::quarter_sine.
module sine_quarter_rom
    import lfo_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int AMP    = AMP_DEF
) (
    input  logic              CLOCK_50,
    input  logic [LUT_AW-1:0] addr,
    output logic [LUT_DW-1:0] data
);

    logic [LUT_DW-1:0] table_w [2**LUT_AW];
    logic [LUT_DW-1:0] data_d;
    logic [LUT_DW-1:0] data_q;

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_entry
        assign table_w[i] = quarter_sine(i, LUT_AW, AMP);
    end

    assign data_d = table_w[addr];

    // NOTE: ROM read register has no reset; it only ever holds table data and
    // a reset port would stop the table from mapping onto block memory.
    always_ff @(posedge CLOCK_50) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/vibrato_lfo.sv
// Sine LFO for the vibrato delay modulation: one phase step per ADCLRCK
// rising edge, depth-scaled output centred on AMP.
module vibrato_lfo
    import lfo_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int AMP     = AMP_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               ADCLRCK,
    input  logic               enable,
    input  logic [PHASE_W-1:0] rate,
    input  logic [8:0]         depth,
    output logic [31:0]        sin,
    output logic               sin_valid,
    output logic               overrun
);

    localparam int               OUT_W     = LUT_DW + 1;
    localparam logic [OUT_W-1:0] MID       = OUT_W'(AMP);
    localparam logic [8:0]       DEPTH_MAX = 9'd256;

    logic               sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    lfo_state_t         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d, rate_q, rate_d;
    logic [8:0]         depth_q, depth_d;
    logic               en_q, en_d;
    logic [OUT_W-1:0]   sin_q, sin_d;
    logic               overrun_q, overrun_d;

    logic                tick;
    quadrant_t           quad;
    logic [LUT_AW-1:0]   rom_addr;
    logic [LUT_DW-1:0]   rom_data;
    logic [2*LUT_DW-1:0] product;
    logic [LUT_DW-1:0]   scaled;
    logic [OUT_W-1:0]    fresh;

    assign tick = sync2_q & ~hist_q;
    assign quad = quadrant_t'(phase_q[PHASE_W-1 -: 2]);

    sine_quarter_rom #(
        .LUT_AW (LUT_AW),
        .AMP    (AMP)
    ) u_rom (
        .CLOCK_50 (CLOCK_50),
        .addr     (rom_addr),
        .data     (rom_data)
    );

    always_comb begin
        rom_addr = phase_q[PHASE_W-3 -: LUT_AW];
        if (quad == Q1_POS_DOWN || quad == Q3_NEG_DOWN) begin
            rom_addr = ~rom_addr;
        end
    end

    // scaled never exceeds AMP, so AMP - scaled cannot underflow.
    always_comb begin
        product = (2*LUT_DW)'(rom_data) * (2*LUT_DW)'(depth_q);
        scaled  = LUT_DW'(product >> 8);
        if (!en_q) begin
            fresh = MID;
        end else if (quad == Q2_NEG_UP || quad == Q3_NEG_DOWN) begin
            fresh = MID - OUT_W'(scaled);
        end else begin
            fresh = MID + OUT_W'(scaled);
        end
    end

    // NOTE: every _d starts as a copy of its _q so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        sync1_d   = ADCLRCK;
        sync2_d   = sync1_q;
        hist_d    = sync2_q;
        state_d   = state_q;
        phase_d   = phase_q;
        rate_d    = rate_q;
        depth_d   = depth_q;
        en_d      = en_q;
        sin_d     = sin_q;
        overrun_d = overrun_q;

        if (tick && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    rate_d  = rate;
                    depth_d = (depth > DEPTH_MAX) ? DEPTH_MAX : depth;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                en_d = enable;
                if (enable) begin
                    phase_d = phase_q + rate_q;
                end
                state_d = LOOKUP;
            end
            LOOKUP: begin
                state_d = OUTPUT;
            end
            OUTPUT: begin
                sin_d   = fresh;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchroniser and edge history reset high: ADCLRCK held high across
    // reset must not look like a rising edge afterwards.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            hist_q    <= 1'b1;
            state_q   <= IDLE;
            phase_q   <= '0;
            rate_q    <= '0;
            depth_q   <= '0;
            en_q      <= 1'b0;
            sin_q     <= MID;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            rate_q    <= rate_d;
            depth_q   <= depth_d;
            en_q      <= en_d;
            sin_q     <= sin_d;
            overrun_q <= overrun_d;
        end
    end

    // The new value is presented during the OUTPUT cycle itself and held in
    // sin_q from then on.
    assign sin_valid = (state_q == OUTPUT);
    assign sin       = 32'(sin_valid ? fresh : sin_q);
    assign overrun   = overrun_q;

endmodule
